// File: rtl/rename_reg_file.sv
// rename_reg_file: architectural register file with per-register ROB rename tags.
// It takes renames from issue and results from the ROB commit port, and serves
// two combinational operand-read ports. x0 is hardwired to zero.
// Optional macro REG_COMMIT_BYPASS_EN: when defined, a commit that is about to
// retire a register's pending tag is forwarded to the read ports in the same cycle.
module rename_reg_file #(
  parameter int ROB_LOG = 4,
  parameter int REG_NUM = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               issue_valid,
  input  logic [4:0]         issue_dest,
  input  logic [ROB_LOG-1:0] issue_RobId,
  input  logic               reg_enable,
  input  logic [4:0]         reg_index,
  input  logic [ROB_LOG-1:0] reg_RobId,
  input  logic [31:0]        reg_value,
  input  logic               jump_flag,
  input  logic [4:0]         rs1_index,
  output logic [31:0]        rs1_value,
  output logic               rs1_busy,
  output logic [ROB_LOG-1:0] rs1_tag,
  input  logic [4:0]         rs2_index,
  output logic [31:0]        rs2_value,
  output logic               rs2_busy,
  output logic [ROB_LOG-1:0] rs2_tag
);

  localparam int IDX_W = 5;

  // Architectural state; entry 0 is never written after reset.
  logic [31:0]        value_r [REG_NUM];
  logic [REG_NUM-1:0] busy_r;
  logic [ROB_LOG-1:0] tag_r   [REG_NUM];

  // Per-register update strobes decoded from the commit and issue ports.
  logic [REG_NUM-1:0] commit_we_s;
  logic [REG_NUM-1:0] commit_clr_s;
  logic [REG_NUM-1:0] rename_we_s;

  // Read-port plumbing, indexed by port number (0 = rs1, 1 = rs2).
  logic [IDX_W-1:0]   rd_idx_s   [2];
  logic [31:0]        rd_value_s [2];
  logic               rd_busy_s  [2];
  logic [ROB_LOG-1:0] rd_tag_s   [2];

  // Decode commit/rename requests into per-register strobes; x0 is skipped.
  always_comb begin
    commit_we_s  = '0;
    commit_clr_s = '0;
    rename_we_s  = '0;
    for (int i = 1; i < REG_NUM; i++) begin
      if (rdy && reg_enable && (reg_index == IDX_W'(i))) begin
        commit_we_s[i]  = 1'b1;
        // Only the commit of the most recent rename frees the register.
        commit_clr_s[i] = busy_r[i] && (tag_r[i] == reg_RobId);
      end else begin
        commit_we_s[i]  = 1'b0;
        commit_clr_s[i] = 1'b0;
      end
      // A flush cancels the instruction being issued alongside it.
      if (rdy && issue_valid && !jump_flag && (issue_dest == IDX_W'(i))) begin
        rename_we_s[i] = 1'b1;
      end else begin
        rename_we_s[i] = 1'b0;
      end
    end
  end

  // Register state update: commit writes values, rename beats commit on busy/tag, flush clears busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        value_r[i] <= 32'd0;
        tag_r[i]   <= '0;
      end
    end else if (rdy) begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (commit_we_s[i]) begin
          value_r[i] <= reg_value;
        end
        if (jump_flag) begin
          busy_r[i] <= 1'b0;
        end else if (rename_we_s[i]) begin
          busy_r[i] <= 1'b1;
        end else if (commit_clr_s[i]) begin
          busy_r[i] <= 1'b0;
        end
        if (rename_we_s[i]) begin
          tag_r[i] <= issue_RobId;
        end
      end
    end
  end

  assign rd_idx_s[0] = rs1_index;
  assign rd_idx_s[1] = rs2_index;

  // Combinational operand lookup, with optional same-cycle commit forwarding.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_value_s[p] = 32'd0;
      rd_busy_s[p]  = 1'b0;
      rd_tag_s[p]   = '0;
      if (rd_idx_s[p] != 5'd0) begin
        rd_value_s[p] = value_r[rd_idx_s[p]];
        rd_busy_s[p]  = busy_r[rd_idx_s[p]];
        rd_tag_s[p]   = tag_r[rd_idx_s[p]];
`ifdef REG_COMMIT_BYPASS_EN
        if (rdy && reg_enable && (rd_idx_s[p] == reg_index) &&
            busy_r[rd_idx_s[p]] && (tag_r[rd_idx_s[p]] == reg_RobId)) begin
          rd_value_s[p] = reg_value;
          rd_busy_s[p]  = 1'b0;
        end else begin
          rd_busy_s[p]  = busy_r[rd_idx_s[p]];
        end
`endif
      end else begin
        rd_value_s[p] = 32'd0;
        rd_busy_s[p]  = 1'b0;
        rd_tag_s[p]   = '0;
      end
    end
  end

  assign rs1_value = rd_value_s[0];
  assign rs1_busy  = rd_busy_s[0];
  assign rs1_tag   = rd_tag_s[0];
  assign rs2_value = rd_value_s[1];
  assign rs2_busy  = rd_busy_s[1];
  assign rs2_tag   = rd_tag_s[1];

endmodule

// File: tb/tb_rename_reg_file.sv
// Self-checking bench for rename_reg_file: directed scenarios followed by
// randomized traffic, compared against a behavioural register/rename model.
module tb_rename_reg_file;

  localparam int ROB_LOG = 4;

  logic               clk;
  logic               rst;
  logic               rdy;
  logic               issue_valid;
  logic [4:0]         issue_dest;
  logic [ROB_LOG-1:0] issue_RobId;
  logic               reg_enable;
  logic [4:0]         reg_index;
  logic [ROB_LOG-1:0] reg_RobId;
  logic [31:0]        reg_value;
  logic               jump_flag;
  logic [4:0]         rs1_index;
  logic [31:0]        rs1_value;
  logic               rs1_busy;
  logic [ROB_LOG-1:0] rs1_tag;
  logic [4:0]         rs2_index;
  logic [31:0]        rs2_value;
  logic               rs2_busy;
  logic [ROB_LOG-1:0] rs2_tag;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0]        m_value [32];
  logic               m_busy  [32];
  logic [ROB_LOG-1:0] m_tag   [32];

  rename_reg_file #(.ROB_LOG(ROB_LOG), .REG_NUM(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_RobId(issue_RobId),
    .reg_enable(reg_enable), .reg_index(reg_index), .reg_RobId(reg_RobId),
    .reg_value(reg_value), .jump_flag(jump_flag),
    .rs1_index(rs1_index), .rs1_value(rs1_value), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
    .rs2_index(rs2_index), .rs2_value(rs2_value), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_value[i] = 32'd0;
      m_busy[i]  = 1'b0;
      m_tag[i]   = '0;
    end
  endtask

  // Apply one clock edge's worth of architectural rules to the model.
  task automatic model_step();
    logic clr;
    if (rdy) begin
      clr = reg_enable && (reg_index != 5'd0) && m_busy[reg_index] && (m_tag[reg_index] == reg_RobId);
      if (reg_enable && reg_index != 5'd0) m_value[reg_index] = reg_value;
      if (clr) m_busy[reg_index] = 1'b0;
      if (!jump_flag && issue_valid && issue_dest != 5'd0) begin
        m_busy[issue_dest] = 1'b1;
        m_tag[issue_dest]  = issue_RobId;
      end
      if (jump_flag) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end
    end
  endtask

  // Expected read-port result for the current model state and current inputs.
  task automatic model_read(input logic [4:0] idx, output logic [31:0] v,
                            output logic b, output logic [ROB_LOG-1:0] t);
    v = 32'd0; b = 1'b0; t = '0;
    if (idx != 5'd0) begin
      v = m_value[idx]; b = m_busy[idx]; t = m_tag[idx];
`ifdef REG_COMMIT_BYPASS_EN
      if (rdy && reg_enable && idx == reg_index && m_busy[idx] && m_tag[idx] == reg_RobId) begin
        v = reg_value; b = 1'b0;
      end
`endif
    end
  endtask

  task automatic check_ports(input string tag);
    logic [31:0] v; logic b; logic [ROB_LOG-1:0] t;
    model_read(rs1_index, v, b, t);
    check({tag, "_rs1_value"}, rs1_value, v);
    check({tag, "_rs1_busy"}, 32'(rs1_busy), 32'(b));
    if (b) check({tag, "_rs1_tag"}, 32'(rs1_tag), 32'(t));
    model_read(rs2_index, v, b, t);
    check({tag, "_rs2_value"}, rs2_value, v);
    check({tag, "_rs2_busy"}, 32'(rs2_busy), 32'(b));
    if (b) check({tag, "_rs2_tag"}, 32'(rs2_tag), 32'(t));
  endtask

  task automatic set_idle();
    rdy = 1'b1; issue_valid = 1'b0; issue_dest = 5'd0; issue_RobId = '0;
    reg_enable = 1'b0; reg_index = 5'd0; reg_RobId = '0; reg_value = 32'd0;
    jump_flag = 1'b0;
  endtask

  // Check reads with current inputs, clock one edge, update model. Ends at edge+1.
  task automatic do_cycle(input string tag);
    #2;
    check_ports(tag);
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Directed read of one register with idle inputs, against fixed expectations.
  task automatic peek(input string name, input logic [4:0] idx, input logic [31:0] ev,
                      input logic eb, input logic [ROB_LOG-1:0] et);
    set_idle();
    rs1_index = idx;
    #1;
    check({name, "_value"}, rs1_value, ev);
    check({name, "_busy"}, 32'(rs1_busy), 32'(eb));
    if (eb) check({name, "_tag"}, 32'(rs1_tag), 32'(et));
  endtask

  task automatic commit(input logic [4:0] idx, input logic [ROB_LOG-1:0] rob, input logic [31:0] val);
    reg_enable = 1'b1; reg_index = idx; reg_RobId = rob; reg_value = val;
  endtask

  task automatic rename(input logic [4:0] idx, input logic [ROB_LOG-1:0] rob);
    issue_valid = 1'b1; issue_dest = idx; issue_RobId = rob;
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    rs1_index = 5'd5; rs2_index = 5'd31;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_rs1_value", rs1_value, 32'd0);
    check("reset_rs1_busy", 32'(rs1_busy), 32'd0);
    check("reset_rs2_busy", 32'(rs2_busy), 32'd0);

    // Rename then commit
    set_idle(); rename(5'd5, 4'd3); do_cycle("t1a");
    peek("t1_renamed", 5'd5, 32'd0, 1'b1, 4'd3);
    commit(5'd5, 4'd3, 32'hDEADBEEF); rs1_index = 5'd5; do_cycle("t1b");
    peek("t1_committed", 5'd5, 32'hDEADBEEF, 1'b0, 4'd0);

    // Stale commit
    set_idle(); rename(5'd7, 4'd2); do_cycle("t2a");
    set_idle(); rename(5'd7, 4'd6); do_cycle("t2b");
    set_idle(); commit(5'd7, 4'd2, 32'h11); do_cycle("t2c");
    peek("t2_stale", 5'd7, 32'h11, 1'b1, 4'd6);
    commit(5'd7, 4'd6, 32'h22); do_cycle("t2d");
    peek("t2_fresh", 5'd7, 32'h22, 1'b0, 4'd0);

    // Same-cycle rename and commit
    set_idle(); rename(5'd9, 4'd1); do_cycle("t3a");
    set_idle(); commit(5'd9, 4'd1, 32'h55); rename(5'd9, 4'd4); do_cycle("t3b");
    peek("t3_same", 5'd9, 32'h55, 1'b1, 4'd4);

    // Flush with commit
    set_idle(); rename(5'd1, 4'd8); do_cycle("t4a");
    set_idle(); rename(5'd2, 4'd9); do_cycle("t4b");
    set_idle(); rename(5'd3, 4'd10); do_cycle("t4c");
    set_idle(); jump_flag = 1'b1; commit(5'd1, 4'd8, 32'h1000); rename(5'd4, 4'd11); do_cycle("t4d");
    peek("t4_x1", 5'd1, 32'h1000, 1'b0, 4'd0);
    peek("t4_x2", 5'd2, 32'd0, 1'b0, 4'd0);
    peek("t4_x3", 5'd3, 32'd0, 1'b0, 4'd0);
    peek("t4_x4", 5'd4, 32'd0, 1'b0, 4'd0);

    // x0 and rdy
    set_idle(); rename(5'd0, 4'd5); commit(5'd0, 4'd5, 32'hFFFFFFFF); do_cycle("t5a");
    peek("t5_x0", 5'd0, 32'd0, 1'b0, 4'd0);
    check("t5_x0_tag", 32'(rs1_tag), 32'd0);
    set_idle(); rdy = 1'b0; commit(5'd8, 4'd0, 32'h88); rename(5'd8, 4'd2); do_cycle("t5b");
    peek("t5_frozen", 5'd8, 32'd0, 1'b0, 4'd0);
    commit(5'd8, 4'd0, 32'h88); do_cycle("t5c");
    peek("t5_applied", 5'd8, 32'h88, 1'b0, 4'd0);

    // Async reset mid-operation
    set_idle(); rename(5'd10, 4'd12); do_cycle("t6a");
    set_idle(); commit(5'd10, 4'd0, 32'h7); do_cycle("t6b");
    peek("t6_before", 5'd10, 32'h7, 1'b1, 4'd12);
    rst = 1'b1;
    #1;
    check("t6_rst_value", rs1_value, 32'd0);
    check("t6_rst_busy", 32'(rs1_busy), 32'd0);
    model_reset();
    #2;
    rst = 1'b0;
    @(posedge clk); #1;

    // Same-cycle read of a matching commit
    set_idle(); rename(5'd11, 4'd13); do_cycle("t7a");
    set_idle(); commit(5'd11, 4'd13, 32'hCAFE); rs1_index = 5'd11;
    #1;
`ifdef REG_COMMIT_BYPASS_EN
    check("t7_bypass_value", rs1_value, 32'hCAFE);
    check("t7_bypass_busy", 32'(rs1_busy), 32'd0);
`else
    check("t7_stored_value", rs1_value, 32'd0);
    check("t7_stored_busy", 32'(rs1_busy), 32'd1);
`endif
    do_cycle("t7b");
    peek("t7_after", 5'd11, 32'hCAFE, 1'b0, 4'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      logic [4:0] ci;
      rdy         = ($urandom_range(0, 9) != 0);
      jump_flag   = ($urandom_range(0, 19) == 0);
      issue_valid = $urandom_range(0, 1) == 1;
      issue_dest  = 5'($urandom_range(0, 7));
      issue_RobId = ROB_LOG'($urandom);
      reg_enable  = $urandom_range(0, 1) == 1;
      ci          = 5'($urandom_range(0, 7));
      reg_index   = ci;
      reg_RobId   = ($urandom_range(0, 3) != 0) ? m_tag[ci] : ROB_LOG'($urandom);
      reg_value   = $urandom;
      rs1_index   = ($urandom_range(0, 1) == 1) ? ci : 5'($urandom_range(0, 31));
      rs2_index   = 5'($urandom_range(0, 8));
      do_cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
